// File: rtl/regdump_sequencer.sv
// Run/dump controller: enables the core for a programmed number of cycles,
// then freezes it and streams r0..r(NUM_REGS-1) out over valid/ready.
module regdump_sequencer #(
    parameter int CYC_W    = 10,
    parameter int NUM_REGS = 32,
    parameter int REG_W    = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [CYC_W-1:0]  num_cycles,
    input  logic              abort,
    input  logic [REG_W-1:0]  cpu_rs1,
    output logic [REG_W-1:0]  ctrl_readRegA,
    input  logic [DATA_W-1:0] data_readRegA,
    output logic              cpu_run,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [REG_W-1:0]  dump_reg,
    output logic [DATA_W-1:0] dump_data,
    output logic [CYC_W-1:0]  cycle_count,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_SCAN,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [REG_W-1:0] LAST_IDX = REG_W'(NUM_REGS - 1);

    state_t            state_q, state_d;
    logic [CYC_W-1:0]  limit_q, limit_d;
    logic [CYC_W-1:0]  cycle_count_q, cycle_count_d;
    logic [REG_W-1:0]  idx_q, idx_d;
    logic              dump_valid_q, dump_valid_d;
    logic [REG_W-1:0]  dump_reg_q, dump_reg_d;
    logic [DATA_W-1:0] dump_data_q, dump_data_d;

    logic last_cycle;
    logic out_free;

    assign last_cycle = (cycle_count_q == limit_q - CYC_W'(1));
    // One-entry output register: reloadable when empty or being drained
    assign out_free   = !dump_valid_q || dump_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = (num_cycles != '0) ? S_RUN : S_SCAN;
                end
            end
            S_RUN: begin
                if (abort || last_cycle) begin
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (out_free && idx_q == LAST_IDX) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (dump_ready) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cpu_run       = (state_q == S_RUN);
        busy          = (state_q == S_RUN) || (state_q == S_SCAN) ||
                        (state_q == S_FLUSH);
        done          = (state_q == S_DONE);
        ctrl_readRegA = ((state_q == S_IDLE) || (state_q == S_RUN)) ?
                        cpu_rs1 : idx_q;
    end

    always_comb begin
        limit_d       = limit_q;
        cycle_count_d = cycle_count_q;
        idx_d         = idx_q;
        dump_valid_d  = dump_valid_q;
        dump_reg_d    = dump_reg_q;
        dump_data_d   = dump_data_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    limit_d       = num_cycles;
                    cycle_count_d = '0;
                    idx_d         = '0;
                end
            end
            S_RUN: begin
                if (!abort) begin
                    cycle_count_d = cycle_count_q + CYC_W'(1);
                end
            end
            S_SCAN: begin
                if (out_free) begin
                    dump_data_d  = data_readRegA;
                    dump_reg_d   = idx_q;
                    dump_valid_d = 1'b1;
                    if (idx_q != LAST_IDX) begin
                        idx_d = idx_q + REG_W'(1);
                    end
                end
            end
            S_FLUSH: begin
                if (dump_ready) begin
                    dump_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            limit_q       <= '0;
            cycle_count_q <= '0;
            idx_q         <= '0;
            dump_valid_q  <= 1'b0;
            dump_reg_q    <= '0;
            dump_data_q   <= '0;
        end else begin
            limit_q       <= limit_d;
            cycle_count_q <= cycle_count_d;
            idx_q         <= idx_d;
            dump_valid_q  <= dump_valid_d;
            dump_reg_q    <= dump_reg_d;
            dump_data_q   <= dump_data_d;
        end
    end

    assign dump_valid  = dump_valid_q;
    assign dump_reg    = dump_reg_q;
    assign dump_data   = dump_data_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_regdump_sequencer.sv
// Bench for regdump_sequencer: scoreboarded register dumps under
// several run lengths, backpressure, abort and asynchronous reset.
module tb_regdump_sequencer;

    logic        clock;
    logic        reset;
    logic        start;
    logic [9:0]  num_cycles;
    logic        abort;
    logic [4:0]  cpu_rs1;
    logic [4:0]  ctrl_readRegA;
    logic [31:0] data_readRegA;
    logic        cpu_run;
    logic        dump_valid;
    logic        dump_ready;
    logic [4:0]  dump_reg;
    logic [31:0] dump_data;
    logic [9:0]  cycle_count;
    logic        busy;
    logic        done;

    logic [31:0] rf [32];
    logic [4:0]  exp_reg_q [$];
    logic [31:0] exp_data_q [$];

    int n_cmp = 0;
    int n_err = 0;

    regdump_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .num_cycles   (num_cycles),
        .abort        (abort),
        .cpu_rs1      (cpu_rs1),
        .ctrl_readRegA(ctrl_readRegA),
        .data_readRegA(data_readRegA),
        .cpu_run      (cpu_run),
        .dump_valid   (dump_valid),
        .dump_ready   (dump_ready),
        .dump_reg     (dump_reg),
        .dump_data    (dump_data),
        .cycle_count  (cycle_count),
        .busy         (busy),
        .done         (done)
    );

    assign data_readRegA = rf[ctrl_readRegA];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic load_rf();
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
    endtask

    // Raises start at a negedge and queues the expected dump; caller's next
    // negedge (normally inside run_dump) drops it again.
    task automatic do_start(input int n);
        @(negedge clock);
        start      = 1'b1;
        num_cycles = 10'(n);
        exp_reg_q.delete();
        exp_data_q.delete();
        for (int i = 0; i < 32; i++) begin
            exp_reg_q.push_back(5'(i));
            exp_data_q.push_back(rf[i]);
        end
    endtask

    // mode 0: ready held high; mode 1: ready pattern 1,0,0,1
    task automatic run_dump(input int mode, input int exp_run,
                            input int exp_count, input string name);
        int cyc = 0;
        int recs = 0;
        int runs = 0;
        int first = -1;
        int last = -1;
        bit fin = 0;
        logic pv = 0;
        logic pacc = 0;
        logic [4:0] preg = '0;
        logic [31:0] pdata = '0;
        logic [4:0] er;
        logic [31:0] ed;
        while (!fin && cyc < 2000) begin
            @(negedge clock);
            start = 1'b0;
            if (mode == 0) dump_ready = 1'b1;
            else dump_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            if (cpu_run) runs++;
            if (pv && !pacc) begin
                n_cmp++;
                if (dump_valid !== 1'b1 || dump_reg !== preg ||
                    dump_data !== pdata) begin
                    n_err++;
                    $display("FAIL %s hold: v=%b reg=%0d data=%h, want v=1 reg=%0d data=%h",
                             name, dump_valid, dump_reg, dump_data, preg, pdata);
                end
            end
            if (done) begin
                n_cmp++;
                if (exp_reg_q.size() != 0) begin
                    n_err++;
                    $display("FAIL %s early_done: %0d records pending, want 0",
                             name, exp_reg_q.size());
                end
                fin = 1;
            end else if (dump_valid && dump_ready) begin
                n_cmp++;
                if (exp_reg_q.size() == 0) begin
                    n_err++;
                    $display("FAIL %s extra_rec: reg=%0d, want none", name, dump_reg);
                end else begin
                    er = exp_reg_q.pop_front();
                    ed = exp_data_q.pop_front();
                    if (dump_reg !== er || dump_data !== ed) begin
                        n_err++;
                        $display("FAIL %s rec: reg=%0d data=%h, want reg=%0d data=%h",
                                 name, dump_reg, dump_data, er, ed);
                    end
                end
                recs++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            pv    = dump_valid;
            pacc  = dump_valid && dump_ready;
            preg  = dump_reg;
            pdata = dump_data;
            cyc++;
        end
        n_cmp++;
        if (!fin) begin
            n_err++;
            $display("FAIL %s timeout: done=%b, want 1", name, done);
        end
        n_cmp++;
        if (recs != 32) begin
            n_err++;
            $display("FAIL %s nrec: %0d, want 32", name, recs);
        end
        if (exp_run >= 0) begin
            n_cmp++;
            if (runs != exp_run) begin
                n_err++;
                $display("FAIL %s run_cycles: %0d, want %0d", name, runs, exp_run);
            end
        end
        n_cmp++;
        if (cycle_count !== 10'(exp_count)) begin
            n_err++;
            $display("FAIL %s cycle_count: %0d, want %0d", name, cycle_count, exp_count);
        end
        if (mode == 0) begin
            n_cmp++;
            if (last - first + 1 != 32) begin
                n_err++;
                $display("FAIL %s span: %0d, want 32", name, last - first + 1);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cpu_rs1 = 5'd17;
        repeat (2) @(negedge clock);
        n_cmp++;
        if (cpu_run !== 1'b0 || dump_valid !== 1'b0 || dump_reg !== 5'd0 ||
            dump_data !== 32'd0 || cycle_count !== 10'd0 || busy !== 1'b0 ||
            done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_vals: run=%b v=%b reg=%0d data=%h cc=%0d busy=%b done=%b, want all 0",
                     cpu_run, dump_valid, dump_reg, dump_data, cycle_count, busy, done);
        end
        n_cmp++;
        if (ctrl_readRegA !== 5'd17) begin
            n_err++;
            $display("FAIL reset_mux: %0d, want 17", ctrl_readRegA);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        load_rf();
        do_start(5);
        run_dump(0, 5, 5, "basic");
    endtask

    task automatic test_zero();
        load_rf();
        do_start(0);
        run_dump(0, 0, 0, "zero");
    endtask

    task automatic test_backpressure();
        load_rf();
        rf[7] = 32'hDEADBEEF;
        do_start(3);
        run_dump(1, 3, 3, "bp");
    endtask

    task automatic test_abort();
        int k = 0;
        load_rf();
        do_start(100);
        do begin
            @(negedge clock);
            start = 1'b0;
            k++;
        end while (cycle_count !== 10'd10 && k < 200);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        n_cmp++;
        if (cpu_run !== 1'b0 || cycle_count !== 10'd10 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL abort: run=%b cc=%0d busy=%b, want run=0 cc=10 busy=1",
                     cpu_run, cycle_count, busy);
        end
        run_dump(0, -1, 10, "abort");
    endtask

    task automatic test_port_mux();
        int k = 0;
        load_rf();
        cpu_rs1 = 5'd3;
        do_start(20);
        @(negedge clock);
        start = 1'b0;
        n_cmp++;
        if (cpu_run !== 1'b1 || ctrl_readRegA !== 5'd3) begin
            n_err++;
            $display("FAIL mux_run: run=%b ctrl=%0d, want run=1 ctrl=3",
                     cpu_run, ctrl_readRegA);
        end
        start = 1'b1;
        num_cycles = 10'd7;
        @(negedge clock);
        start = 1'b0;
        cpu_rs1 = 5'd9;
        while (cpu_run === 1'b1 && k < 100) begin
            @(negedge clock);
            k++;
        end
        n_cmp++;
        if (ctrl_readRegA !== 5'd0 || dump_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mux_scan: ctrl=%0d v=%b, want ctrl=0 v=0",
                     ctrl_readRegA, dump_valid);
        end
        run_dump(0, -1, 20, "mux");
    endtask

    task automatic test_async_reset();
        int k = 0;
        load_rf();
        do_start(2);
        do begin
            @(negedge clock);
            start = 1'b0;
            dump_ready = 1'b1;
            if (dump_valid && dump_reg == 5'd11) dump_ready = 1'b0;
            k++;
        end while (dump_ready && k < 200);
        #2;
        reset = 1'b1;
        cpu_rs1 = 5'd21;
        #1;
        n_cmp++;
        if (dump_valid !== 1'b0 || busy !== 1'b0 || cpu_run !== 1'b0 ||
            ctrl_readRegA !== 5'd21 || cycle_count !== 10'd0) begin
            n_err++;
            $display("FAIL areset: v=%b busy=%b run=%b ctrl=%0d cc=%0d, want 0 0 0 21 0",
                     dump_valid, busy, cpu_run, ctrl_readRegA, cycle_count);
        end
        @(negedge clock);
        reset = 1'b0;
        dump_ready = 1'b1;
        exp_reg_q.delete();
        exp_data_q.delete();
        repeat (3) begin
            @(negedge clock);
            n_cmp++;
            if (dump_valid !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL post_reset: v=%b busy=%b, want 0 0", dump_valid, busy);
            end
        end
        load_rf();
        do_start(4);
        run_dump(0, 4, 4, "after_reset");
    endtask

    initial begin
        start = 1'b0;
        num_cycles = '0;
        abort = 1'b0;
        dump_ready = 1'b1;
        load_rf();
        test_reset();
        test_basic();
        test_zero();
        test_backpressure();
        test_abort();
        test_port_mux();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regdump_sequencer.md
Name: regdump_sequencer

Overview:
- Run/dump controller for the processor core.
- Enables the core for a programmed number of cycles, then freezes it.
- Takes over regfile read port A and streams all registers (r0..r31) out over a valid/ready interface.
- Replaces behavioural test-harness sequencing with synthesizable logic usable on FPGA and in simulation.

Parameters:
- CYC_W, 10, width of the cycle-count input and counter.
- NUM_REGS, 32, number of registers scanned, indices 0..NUM_REGS-1.
- REG_W, 5, width of a register index.
- DATA_W, 32, register data width.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  one-cycle pulse; begins a run when in IDLE.
- num_cycles  in  CYC_W  run length; sampled on an accepted start.
- abort  in  1  ends RUN early and proceeds to SCAN.
- cpu_rs1  in  REG_W  processor's requested read-port-A index.
- ctrl_readRegA  out  REG_W  index driven to regfile port A.
- data_readRegA  in  DATA_W  regfile port A data; combinational read.
- cpu_run  out  1  processor clock enable.
- dump_valid  out  1  dump_reg/dump_data hold a valid record.
- dump_ready  in  1  consumer accepts a record when valid and ready are both high.
- dump_reg  out  REG_W  register index of the current record.
- dump_data  out  DATA_W  register value of the current record.
- cycle_count  out  CYC_W  number of enabled cycles completed in this run.
- busy  out  1  high in RUN, SCAN and FLUSH.
- done  out  1  high in DONE.

Behaviour:
- Reset values:
  - state=IDLE, cpu_run=0, dump_valid=0, dump_reg=0, dump_data=0, cycle_count=0, busy=0, done=0.
  - Internal scan index idx=0.
- Read-port mux:
  - ctrl_readRegA = cpu_rs1 in IDLE and RUN.
  - ctrl_readRegA = idx in SCAN, FLUSH and DONE.
  - Mux is combinational.
- cpu_run: combinational, equal to (state==RUN).
- IDLE:
  - On start: latch num_cycles into limit, clear cycle_count and idx, clear done.
  - If limit≠0, go to RUN; if limit==0, go directly to SCAN. The core never runs in that case.
- RUN:
  - Each cycle, cycle_count increments by 1.
  - When cycle_count==limit-1 and increments, go to SCAN. The core sees exactly limit enabled edges.
  - If abort is high, go to SCAN on that edge with no increment; abort has priority over the increment.
  - start is ignored while in RUN.
- SCAN (one-entry output register):
  - Output register is free when dump_valid==0, or when dump_valid && dump_ready.
  - On each free edge: dump_data <= data_readRegA, dump_reg <= idx, dump_valid <= 1.
  - If idx==NUM_REGS-1, go to FLUSH; otherwise idx <= idx+1.
  - Throughput is one record per cycle with dump_ready held high.
  - dump_valid never drops while a record is unaccepted.
  - dump_reg and dump_data are stable while valid && !ready.
- FLUSH:
  - On dump_ready, dump_valid <= 0 and state <= DONE.
- DONE:
  - done=1; cycle_count holds its final value.
  - start begins a new run with the same handling as in IDLE.
- abort outside RUN: ignored.
- Reset mid-operation (any state): immediate return to reset values.
  - cpu_run drops asynchronously.
  - A partially streamed dump is discarded; no further records are emitted.
- Record order: strictly r0, r1, …, r(NUM_REGS-1); exactly NUM_REGS records per run, none skipped or duplicated.
- Latency:
  - First record is valid on the edge after entering SCAN.
  - Final transfer to done=1 takes one edge after the last handshake.

Test Plan:
- Basic run:
  - Stimulus: start with num_cycles=5, dump_ready held at 1.
  - Required: cpu_run high for exactly 5 cycles; cycle_count=5.
  - Required: 32 records with dump_reg 0..31 on 32 consecutive cycles, then done=1.
- Zero-length run:
  - Stimulus: start with num_cycles=0.
  - Required: cpu_run never asserts; cycle_count=0; 32 records still emitted.
- Backpressure:
  - Stimulus: regfile preloaded with r7=0xDEADBEEF; dump_ready toggled 1,0,0,1 repeatedly.
  - Required: record r7 carries 0xDEADBEEF and is held stable through the ready=0 cycles.
  - Required: no index lost or repeated; done only after record r31 is accepted.
- Abort:
  - Stimulus: num_cycles=100, abort pulsed when cycle_count=10.
  - Required: cpu_run low from the next cycle; cycle_count stays 10; scan proceeds normally.
- Port mux:
  - In RUN with cpu_rs1=3: ctrl_readRegA=3.
  - In SCAN: ctrl_readRegA follows idx regardless of cpu_rs1.
  - start pulsed during RUN is ignored.
- Async reset:
  - Stimulus: reset asserted mid-clock-period during SCAN at idx=12.
  - Required: immediately dump_valid=0, busy=0, state IDLE.
  - Required: after release, a fresh start yields a full r0..r31 dump.
